// File: rtl/ti_pkg.sv
// ============================================================================
// Module : ti_pkg
// Brief  : Shared widths and LFSR helpers for the TI share codec.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ti_pkg;

    localparam int LFSR_W = 16;
    localparam int NIB_W  = 4;
    localparam int SH_W   = 8;

    localparam logic [LFSR_W-1:0] LFSR_ZERO_FIX = 16'h0001;

    // Fibonacci, right shift, taps at bits 0/2/3/5.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[LFSR_W-1:1]};
    endfunction

    function automatic logic [NIB_W-1:0] mask_of(input logic [LFSR_W-1:0] s);
        return s[NIB_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ti_skid1.sv
// ============================================================================
// Module : ti_skid1
// Brief  : Single-entry registered valid/ready stage, full throughput.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ti_skid1 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_accept;

    // Ready depends only on the output side, so a drain and a refill can share a cycle.
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ti_share_codec.sv
// ============================================================================
// Module : ti_share_codec
// Brief  : Boolean-share encoder (LFSR mask) and decoder for the TI S-box bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ti_share_codec
    import ti_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_value,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIB_W-1:0]  in_data,
    output logic              sh_valid,
    input  logic              sh_ready,
    output logic [SH_W-1:0]   sh_data,
    input  logic              rs_valid,
    output logic              rs_ready,
    input  logic [SH_W-1:0]   rs_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_data
);

    localparam logic [LFSR_W-1:0] c_LFSR_RST = (SEED == '0) ? LFSR_ZERO_FIX : SEED;

    logic [LFSR_W-1:0] r_lfsr;
    logic [NIB_W-1:0]  w_mask;
    logic [SH_W-1:0]   w_enc_word;
    logic [NIB_W-1:0]  w_dec_nib;
    logic              w_enc_accept;

    assign w_mask       = mask_of(r_lfsr);
    // The only place x meets m; the result lands directly in the share register.
    assign w_enc_word   = {w_mask, in_data ^ w_mask};
    assign w_dec_nib    = rs_data[SH_W-1:NIB_W] ^ rs_data[NIB_W-1:0];
    assign w_enc_accept = in_valid && in_ready;

    // Mask advances per accepted word only; a seed load wins over advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= c_LFSR_RST;
        end else if (seed_load) begin
            r_lfsr <= (seed_value == '0) ? LFSR_ZERO_FIX : seed_value;
        end else if (w_enc_accept) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    ti_skid1 #(
        .W (SH_W)
    ) u_enc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_enc_word),
        .out_valid (sh_valid),
        .out_ready (sh_ready),
        .out_data  (sh_data)
    );

    ti_skid1 #(
        .W (NIB_W)
    ) u_dec (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rs_valid),
        .in_ready  (rs_ready),
        .in_data   (w_dec_nib),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_ti_share_codec.sv
// ============================================================================
// Module : tb_ti_share_codec
// Brief  : Directed self-checking bench for ti_share_codec.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ti_share_codec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_value = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic        sh_valid;
    logic [7:0]  sh_data;
    logic        rs_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_data;

    logic        sh_ready_t = 1'b0;
    logic        rs_valid_t = 1'b0;
    logic [7:0]  rs_data_t  = '0;
    logic        loop_en    = 1'b0;
    logic        stall      = 1'b0;

    logic        sh_ready_d;
    logic        rs_valid_d;
    logic [7:0]  rs_data_d;

    int n_vec    = 0;
    int n_miscmp = 0;

    // Loopback routes the shared bus straight into the decoder with an injectable stall.
    assign sh_ready_d = loop_en ? (rs_ready && !stall) : sh_ready_t;
    assign rs_valid_d = loop_en ? (sh_valid && !stall) : rs_valid_t;
    assign rs_data_d  = loop_en ? sh_data : rs_data_t;

    always #5 clk = ~clk;

    ti_share_codec #(
        .SEED (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sh_valid   (sh_valid),
        .sh_ready   (sh_ready_d),
        .sh_data    (sh_data),
        .rs_valid   (rs_valid_d),
        .rs_ready   (rs_ready),
        .rs_data    (rs_data_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid   = 1'b0;
        seed_load  = 1'b0;
        sh_ready_t = 1'b0;
        rs_valid_t = 1'b0;
        out_ready  = 1'b0;
        loop_en    = 1'b0;
        stall      = 1'b0;
        rst_n      = 1'b0;
        #2;
        rst_n      = 1'b1;
    endtask

    initial begin
        int sent;
        int rx;
        logic acc_in;
        logic acc_out;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_sh_valid",  16'(sh_valid),  16'h0);
        check_val("rst_sh_data",   16'(sh_data),   16'h00);
        check_val("rst_out_valid", 16'(out_valid), 16'h0);
        check_val("rst_out_data",  16'(out_data),  16'h0);
        check_val("rst_in_ready",  16'(in_ready),  16'h1);
        check_val("rst_rs_ready",  16'(rs_ready),  16'h1);
        check_val("rst_lfsr",      dut.r_lfsr,     16'hACE1);

        // ---------------- three back-to-back nibbles of 6
        @(negedge clk);
        sh_ready_t = 1'b1;
        in_valid   = 1'b1;
        in_data    = 4'h6;
        @(negedge clk);
        check_val("b2b_v0",    16'(sh_valid), 16'h1);
        check_val("b2b_d0",    16'(sh_data),  16'h17);
        check_val("b2b_lfsr0", dut.r_lfsr,    16'h5670);
        @(negedge clk);
        check_val("b2b_d1",    16'(sh_data),  16'h06);
        check_val("b2b_lfsr1", dut.r_lfsr,    16'hAB38);
        @(negedge clk);
        check_val("b2b_d2",    16'(sh_data),  16'h8E);
        check_val("b2b_lfsr2", dut.r_lfsr,    16'h559C);
        in_valid = 1'b0;
        @(negedge clk);
        check_val("drain_valid", 16'(sh_valid), 16'h0);
        check_val("drain_hold",  16'(sh_data),  16'h8E);
        check_val("idle_lfsr",   dut.r_lfsr,    16'h559C);

        // ---------------- backpressure
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'h6;
        @(negedge clk);
        check_val("bp_d0", 16'(sh_data), 16'h17);
        in_data = 4'h9;
        #1;
        check_val("bp_in_ready", 16'(in_ready), 16'h0);
        repeat (2) @(negedge clk);
        check_val("bp_hold",  16'(sh_data), 16'h17);
        check_val("bp_lfsr",  dut.r_lfsr,   16'h5670);
        sh_ready_t = 1'b1;
        @(negedge clk);
        check_val("bp_next",      16'(sh_data), 16'h09);
        check_val("bp_next_lfsr", dut.r_lfsr,   16'hAB38);
        in_valid = 1'b0;
        @(negedge clk);

        // ---------------- seed_load of zero while idle, then load during accept
        seed_load  = 1'b1;
        seed_value = 16'h0000;
        @(negedge clk);
        seed_load = 1'b0;
        check_val("seed0_lfsr",  dut.r_lfsr,   16'h0001);
        check_val("seed0_valid", 16'(sh_valid), 16'h0);
        in_valid = 1'b1;
        in_data  = 4'hF;
        @(negedge clk);
        check_val("seed0_word", 16'(sh_data), 16'h1E);
        check_val("seed0_adv",  dut.r_lfsr,   16'h8000);
        in_data    = 4'h3;
        seed_load  = 1'b1;
        seed_value = 16'h1234;
        @(negedge clk);
        seed_load = 1'b0;
        in_valid  = 1'b0;
        check_val("seedacc_word", 16'(sh_data), 16'h03);
        check_val("seedacc_lfsr", dut.r_lfsr,   16'h1234);
        @(negedge clk);

        // ---------------- decoder
        out_ready  = 1'b1;
        rs_valid_t = 1'b1;
        rs_data_t  = 8'h17;
        @(negedge clk);
        check_val("dec_v0", 16'(out_valid), 16'h1);
        check_val("dec_d0", 16'(out_data),  16'h6);
        rs_data_t = 8'h8E;
        @(negedge clk);
        check_val("dec_v1", 16'(out_valid), 16'h1);
        check_val("dec_d1", 16'(out_data),  16'h6);
        rs_data_t = 8'h3A;
        out_ready = 1'b0;
        #1;
        check_val("dec_rs_ready", 16'(rs_ready), 16'h0);
        @(negedge clk);
        check_val("dec_hold", 16'(out_data), 16'h6);
        out_ready = 1'b1;
        @(negedge clk);
        check_val("dec_d2", 16'(out_data), 16'h9);
        rs_valid_t = 1'b0;
        @(negedge clk);
        check_val("dec_drain", 16'(out_valid), 16'h0);

        // ---------------- round trip with random stalls
        do_reset();
        loop_en = 1'b1;
        sent = 0;
        rx   = 0;
        for (int cyc = 0; cyc < 400 && rx < 16; cyc++) begin
            @(negedge clk);
            stall     = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 16) && ($urandom_range(0, 4) != 0);
            in_data   = 4'(sent);
            #1;
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                check_val("rt_data", 16'(out_data), 16'(rx));
                rx++;
            end
            if (acc_in) sent++;
        end
        check_val("rt_count", 16'(rx), 16'd16);
        @(negedge clk);
        in_valid  = 1'b0;
        stall     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rt_no_extra_out", 16'(out_valid), 16'h0);
        check_val("rt_no_extra_sh",  16'(sh_valid),  16'h0);
        loop_en = 1'b0;

        // ---------------- async reset mid-burst
        do_reset();
        sh_ready_t = 1'b1;
        in_valid   = 1'b1;
        in_data    = 4'h6;
        @(negedge clk);
        sh_ready_t = 1'b0;
        in_data    = 4'hC;
        rs_valid_t = 1'b1;
        rs_data_t  = 8'h17;
        out_ready  = 1'b0;
        @(negedge clk);
        check_val("ar_pre_sh",  16'(sh_valid),  16'h1);
        check_val("ar_pre_out", 16'(out_valid), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_sh_valid",  16'(sh_valid),  16'h0);
        check_val("ar_out_valid", 16'(out_valid), 16'h0);
        check_val("ar_sh_data",   16'(sh_data),   16'h00);
        check_val("ar_lfsr",      dut.r_lfsr,     16'hACE1);
        rst_n      = 1'b1;
        rs_valid_t = 1'b0;
        sh_ready_t = 1'b1;
        @(negedge clk);
        check_val("ar_first_word", 16'(sh_data), 16'h1D);
        in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

`default_nettype wire
